mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: access size, owner, read tag.
// Also holds the alignment helpers used by the MA request path.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [1:0] off;
    size_e      size;
    logic       err;
  } rd_tag_t;

  function automatic logic misaligned(size_e sz, logic [1:0] off);
    logic m;
    unique case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = |off;
      SZ_RSVD: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] align_off(size_e sz, logic [1:0] off);
    logic [1:0] o;
    unique case (sz)
      SZ_BYTE: o = off;
      SZ_HALF: o = {off[1], 1'b0};
      SZ_WORD: o = 2'b00;
      SZ_RSVD: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store lane mask and data replication,
// and load extraction with zero-extension to the access size.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_data,
  input  size_e       i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [31:0] shifted;

  always_comb begin
    o_st_be   = 4'b1111;
    o_st_data = i_st_data;
    unique case (i_st_size)
      SZ_BYTE: begin
        o_st_be   = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_st_be   = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = i_ld_word >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = shifted;
    unique case (i_ld_size)
      SZ_BYTE: o_ld_data = {24'h0, shifted[7:0]};
      SZ_HALF: o_ld_data = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter, MA over IF with starvation escape.
// MEM_ARB_MISALIGN_ERR_EN: misaligned MA accesses raise o_ma_err.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic              i_ma_req,
  input  logic              i_ma_we,
  input  logic [31:0]       i_ma_addr,
  input  logic [31:0]       i_ma_wdata,
  input  logic [1:0]        i_ma_size,
  output logic              o_ma_gnt,
  output logic              o_ma_rvalid,
  output logic [31:0]       o_ma_rdata,
  output logic              o_ma_err,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_stall
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q;
  rd_tag_t       tag_q;
  rd_tag_t       tag_d;
  size_e         ma_size;
  logic          ma_mis;
  logic [1:0]    ma_off;
  logic          if_pri;
  logic          ma_issue;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic [31:0]   ld_data;
  logic          unused_addr;

  assign ma_size = size_e'(i_ma_size);

`ifdef MEM_ARB_MISALIGN_ERR_EN
  assign ma_mis = misaligned(ma_size, i_ma_addr[1:0]);
  assign ma_off = i_ma_addr[1:0];
`else
  assign ma_mis = 1'b0;
  assign ma_off = align_off(ma_size, i_ma_addr[1:0]);
`endif

  // IF wins only once MA has held the port STARVE_MAX times
  assign if_pri   = i_if_req && (starve_q == CW'(STARVE_MAX));
  assign o_ma_gnt = i_clk_en && i_ma_req && !if_pri;
  assign o_if_gnt = i_clk_en && i_if_req && !o_ma_gnt;
  assign ma_issue = o_ma_gnt && !ma_mis;

  assign o_ram_en    = ma_issue || o_if_gnt;
  assign o_ram_we    = (ma_issue && i_ma_we) ? st_be : 4'b0000;
  assign o_ram_wdata = st_data;
  assign o_ram_addr  = o_ma_gnt ? i_ma_addr[ADDR_W+1:2]
                                : i_if_addr[ADDR_W+1:2];

  assign o_stall = (i_ma_req && !o_ma_gnt) || (i_if_req && !o_if_gnt);

  assign unused_addr = ^{i_ma_addr[31:ADDR_W+2],
                         i_if_addr[31:ADDR_W+2],
                         i_if_addr[1:0]};

  mem_lane_align u_lane (
    .i_st_size (ma_size),
    .i_st_off  (ma_off),
    .i_st_data (i_ma_wdata),
    .o_st_be   (st_be),
    .o_st_data (st_data),
    .i_ld_size (tag_q.size),
    .i_ld_off  (tag_q.off),
    .i_ld_word (i_ram_rdata),
    .o_ld_data (ld_data)
  );

  always_comb begin
    tag_d = '{valid: 1'b0, owner: OWN_IF, off: 2'b00,
              size: SZ_WORD, err: 1'b0};
    if (o_ma_gnt) begin
      tag_d.valid = !i_ma_we || ma_mis;
      tag_d.owner = OWN_MA;
      tag_d.off   = ma_off;
      tag_d.size  = ma_size;
      tag_d.err   = ma_mis;
    end else if (o_if_gnt) begin
      tag_d.valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q <= '{valid: 1'b0, owner: OWN_IF, off: 2'b00,
                 size: SZ_WORD, err: 1'b0};
    end else begin
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else if (i_clk_en) begin
      if (o_if_gnt || !i_if_req) begin
        starve_q <= '0;
      end else if (o_ma_gnt && starve_q != CW'(STARVE_MAX)) begin
        starve_q <= starve_q + CW'(1);
      end
    end
  end

  assign o_ma_rvalid = tag_q.valid && tag_q.owner == OWN_MA && !tag_q.err;
  assign o_if_rvalid = tag_q.valid && tag_q.owner == OWN_IF;
  assign o_ma_err    = tag_q.valid && tag_q.err;
  assign o_ma_rdata  = o_ma_rvalid ? ld_data : 32'h0;
  assign o_if_rdata  = o_if_rvalid ? i_ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a
// byte-addressed reference memory and rule-level grant model.
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int SMAX = 4;
`ifdef MEM_ARB_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          ma_req = 1'b0;
  logic          ma_we = 1'b0;
  logic [31:0]   ma_addr = '0;
  logic [31:0]   ma_wdata = '0;
  logic [1:0]    ma_size = '0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          o_ma_gnt, o_ma_rvalid, o_ma_err;
  logic [31:0]   o_ma_rdata;
  logic          o_if_gnt, o_if_rvalid;
  logic [31:0]   o_if_rdata;
  logic          o_ram_en;
  logic [3:0]    o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic          o_stall;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  logic [31:0]   ram [1024];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
    .i_ma_req(ma_req), .i_ma_we(ma_we), .i_ma_addr(ma_addr),
    .i_ma_wdata(ma_wdata), .i_ma_size(ma_size),
    .o_ma_gnt(o_ma_gnt), .o_ma_rvalid(o_ma_rvalid),
    .o_ma_rdata(o_ma_rdata), .o_ma_err(o_ma_err),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid),
    .o_if_rdata(o_if_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(ram_rdata), .o_stall(o_stall)
  );

  // synchronous RAM with byte enables, one-cycle read latency
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (o_ram_en) begin
      ram_rdata <= ram[o_ram_addr];
      for (int b = 0; b < 4; b++)
        if (o_ram_we[b]) ram[o_ram_addr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  logic [7:0]  refm [4096];
  int          starve = 0;
  bit          pend_ma_rv = 0, pend_if_rv = 0, pend_err = 0;
  logic [31:0] pend_ma_rd = '0, pend_if_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int eff_off(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd0) return int'(a[1:0]);
    if (sz == 2'd1) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic bit misal(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return a[1:0] != 2'b00;
    return sz == 2'd3;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, int n, int off);
    logic [31:0] v = '0;
    int base = int'(a[11:2]) * 4;
    for (int k = 0; k < n; k++) v |= 32'(refm[base + off + k]) << (8 * k);
    return v;
  endfunction

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    ma_req = 0; if_req = 0; ma_we = 0;
    pl_en = 1; pl_addr = AW'(idx); pl_data = d;
    for (int k = 0; k < 4; k++) refm[idx * 4 + k] = d[8*k +: 8];
    @(negedge clk);
    pl_en = 0;
    pend_ma_rv = 0; pend_if_rv = 0; pend_err = 0;
  endtask

  task automatic step(input bit en, input bit mr, input bit mw,
                      input logic [31:0] ma, input logic [31:0] wd,
                      input logic [1:0] sz, input bit ir,
                      input logic [31:0] ia);
    bit g_ma, g_if, mis, iss;
    int off, n, base;
    logic [3:0] we;
    logic [31:0] wx;
    @(negedge clk);
    clk_en = en; ma_req = mr; ma_we = mw; ma_addr = ma;
    ma_wdata = wd; ma_size = sz; if_req = ir; if_addr = ia;
    #1;
    chk("ma_rvalid", 32'(o_ma_rvalid), 32'(pend_ma_rv));
    chk("ma_rdata", o_ma_rdata, pend_ma_rv ? pend_ma_rd : 32'h0);
    chk("if_rvalid", 32'(o_if_rvalid), 32'(pend_if_rv));
    chk("if_rdata", o_if_rdata, pend_if_rv ? pend_if_rd : 32'h0);
    chk("ma_err", 32'(o_ma_err), 32'(pend_err));
    g_ma = en && mr && !(ir && starve == SMAX);
    g_if = en && ir && !g_ma;
    mis = ERR_EN && misal(sz, ma);
    iss = g_ma && !mis;
    off = mis ? int'(ma[1:0]) : eff_off(sz, ma);
    n = nbytes(sz);
    base = int'(ma[11:2]) * 4;
    chk("ma_gnt", 32'(o_ma_gnt), 32'(g_ma));
    chk("if_gnt", 32'(o_if_gnt), 32'(g_if));
    chk("ram_en", 32'(o_ram_en), 32'(g_if || iss));
    chk("stall", 32'(o_stall), 32'((mr && !g_ma) || (ir && !g_if)));
    if (g_if) begin
      chk("if_ram_addr", 32'(o_ram_addr), 32'(ia[11:2]));
      chk("if_ram_we", 32'(o_ram_we), 32'h0);
    end
    if (iss) begin
      chk("ma_ram_addr", 32'(o_ram_addr), 32'(ma[11:2]));
      if (mw) begin
        we = '0;
        for (int k = 0; k < n; k++) we[off + k] = 1'b1;
        wx = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        chk("ma_ram_we", 32'(o_ram_we), 32'(we));
        chk("ma_ram_wdata", o_ram_wdata, wx);
        for (int k = 0; k < n; k++) refm[base + off + k] = wd[8*k +: 8];
      end else begin
        chk("ma_ram_we_ld", 32'(o_ram_we), 32'h0);
      end
    end
    pend_if_rv = g_if;
    pend_if_rd = ref_load(ia, 4, 0);
    pend_ma_rv = iss && !mw;
    pend_ma_rd = ref_load(ma, n, off);
    pend_err = g_ma && mis;
    if (en) begin
      if (g_if || !ir) starve = 0;
      else if (g_ma && starve < SMAX) starve++;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) poke(i, $urandom);
    #1;
    chk("rst_ma_gnt", 32'(o_ma_gnt), 32'h0);
    chk("rst_ma_rvalid", 32'(o_ma_rvalid), 32'h0);
    chk("rst_if_rvalid", 32'(o_if_rvalid), 32'h0);
    chk("rst_ma_err", 32'(o_ma_err), 32'h0);
    chk("rst_rdata", o_ma_rdata | o_if_rdata, 32'h0);
    chk("rst_ram_en", 32'(o_ram_en), 32'h0);
    chk("rst_stall", 32'(o_stall), 32'h0);
    @(negedge clk);
    rst_n = 1;

    poke(32'h10, 32'h11223344);
    step(1, 1, 0, 32'h40, 0, 2, 1, 32'h40);
    chk("req028_gnt", {o_ma_gnt, o_if_gnt}, 32'h2);
    chk("req028_stall", 32'(o_stall), 32'h1);
    step(1, 0, 0, 0, 0, 0, 1, 32'h40);
    chk("req028_rvalid", 32'(o_ma_rvalid), 32'h1);
    chk("req028_rdata", o_ma_rdata, 32'h11223344);
    idle();
    idle();
    chk("idle_ram_en", 32'(o_ram_en), 32'h0);
    chk("idle_stall", 32'(o_stall), 32'h0);

    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 32'(i * 4), 0, 2, 1, 32'h80);
      chk("req029_gnt", {o_ma_gnt, o_if_gnt}, (i < 4) ? 32'h2 : 32'h1);
    end
    step(1, 1, 0, 32'h20, 0, 2, 1, 32'h80);
    chk("req029_after", {o_ma_gnt, o_if_gnt}, 32'h2);
    idle();

    step(1, 1, 1, 32'h103, 32'h000000AB, 0, 0, 0);
    chk("req030_we", 32'(o_ram_we), 32'h8);
    chk("req030_addr", 32'(o_ram_addr), 32'h40);
    chk("req030_wdata", o_ram_wdata, 32'hABABABAB);
    idle();
    poke(32'h40, 32'hDEADBEEF);
    step(1, 1, 0, 32'h102, 0, 1, 0, 0);
    idle();
    chk("req031_rdata", o_ma_rdata, 32'h0000DEAD);

    step(1, 1, 0, 32'h44, 0, 2, 0, 0);
    step(0, 1, 0, 32'h48, 0, 2, 1, 32'h4);
    chk("clken_gnt", {o_ma_gnt, o_if_gnt}, 32'h0);
    chk("clken_rv", 32'(o_ma_rvalid), 32'h1);
    idle();

    step(1, 1, 0, 32'h2, 0, 2, 0, 0);
    if (ERR_EN) begin
      chk("req033_en", 32'(o_ram_en), 32'h0);
      idle();
      chk("req033_err", 32'(o_ma_err), 32'h1);
    end else begin
      chk("req033_addr", 32'(o_ram_addr), 32'h0);
      idle();
      chk("req033_rdata", o_ma_rdata, ref_load(32'h0, 4, 0));
    end
    idle();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
           $urandom, $urandom, 2'($urandom_range(0, 3)),
           1'($urandom), $urandom);
    idle();
    idle();

    step(1, 0, 0, 0, 0, 0, 1, 32'h10);
    chk("req032_gnt", 32'(o_if_gnt), 32'h1);
    #1 rst_n = 0;
    if_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("req032_rv", 32'(o_if_rvalid | o_ma_rvalid), 32'h0);
      chk("req032_rdata", o_if_rdata | o_ma_rdata, 32'h0);
      chk("req032_misc", {o_ma_err, o_ram_en, o_stall, o_ma_gnt}, 32'h0);
    end
    pend_ma_rv = 0; pend_if_rv = 0; pend_err = 0; starve = 0;
    @(posedge clk);
    #2 rst_n = 1;
    step(1, 1, 0, 32'h10, 0, 2, 0, 0);
    chk("req023_gnt", 32'(o_ma_gnt), 32'h1);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
